// File: rtl/video_timing_pkg.sv
// Shared timing defaults, pattern codes and colour-bar palette for the
// SiI9136 test-pattern source.
package video_timing_pkg;

  localparam int unsigned CNT_W = 12;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  localparam logic [35:0] COL_WHITE   = 36'hFFF_FFF_FFF;
  localparam logic [35:0] COL_YELLOW  = 36'hFFF_FFF_000;
  localparam logic [35:0] COL_CYAN    = 36'h000_FFF_FFF;
  localparam logic [35:0] COL_GREEN   = 36'h000_FFF_000;
  localparam logic [35:0] COL_MAGENTA = 36'hFFF_000_FFF;
  localparam logic [35:0] COL_RED     = 36'hFFF_000_000;
  localparam logic [35:0] COL_BLUE    = 36'h000_000_FFF;
  localparam logic [35:0] COL_BLACK   = 36'h000_000_000;

  function automatic logic [35:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vid_timing_cntr.sv
// Horizontal/vertical raster counters with combinational region decode.
// All decode outputs are gated by enable so an idle generator reads as blank.
module vid_timing_cntr
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [11:0] h_cnt,
  output logic        v_bit5,
  output logic        active,
  output logic        hs_act,
  output logic        vs_act,
  output logic        first_px
);

  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (enable) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    h_cnt    = h_cnt_q;
    v_bit5   = v_cnt_q[5];
    active   = enable && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_act   = enable && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    vs_act   = enable && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    first_px = enable && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern source; pattern selection is latched only
// at the first pixel of a frame so a frame is never torn.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [35:0] solid_rgb,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [35:0] d,
  output logic        frame_start
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [11:0] h_cnt;
  logic        v_bit5, active, hs_act, vs_act, first_px;

  logic [1:0]  pat_q, pat_d;
  logic [2:0]  bar_idx;
  logic [35:0] pixel;
  logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
  logic [35:0] d_q, d_d;

  vid_timing_cntr #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_cntr (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .h_cnt    (h_cnt),
    .v_bit5   (v_bit5),
    .active   (active),
    .hs_act   (hs_act),
    .vs_act   (vs_act),
    .first_px (first_px)
  );

  // The selection sampled at (0,0) is used for that very pixel, not a frame later.
  always_comb begin
    pat_d = first_px ? pattern_sel : pat_q;
  end

  always_comb begin
    bar_idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h_cnt >= 12'(i * BAR_W)) bar_idx = 3'(i);
    end
    case (pat_d)
      PAT_BARS:  pixel = bar_color(bar_idx);
      PAT_RAMP:  pixel = {3{{h_cnt[9:0], 2'b00}}};
      PAT_CHECK: pixel = (h_cnt[5] ^ v_bit5) ? COL_WHITE : COL_BLACK;
      default:   pixel = solid_rgb;
    endcase
    de_d    = active;
    d_d     = active ? pixel : '0;
    hsync_d = hs_act ? HS_POL : ~HS_POL;
    vsync_d = vs_act ? VS_POL : ~VS_POL;
    fs_d    = first_px;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= PAT_BARS;
      de_q    <= 1'b0;
      d_q     <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      fs_q    <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      de_q    <= de_d;
      d_q     <= d_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    de          = de_q;
    d           = d_q;
    hsync       = hsync_q;
    vsync       = vsync_q;
    frame_start = fs_q;
  end

endmodule
